// File: rtl/note_tone_player.sv
// ---------------------------------------------------------------------------
// note_tone_player
//
// Playback end of the note path. Takes (pitch, duration) note words from the
// song sequencer and plays each as a square wave on a buzzer/speaker pin.
// The pitch is a half-period in clk cycles, produced by a down-counting
// divider. The duration is a count of externally supplied beat ticks. A fixed
// silent gap of GAP_CYC clk cycles follows every note.
//
// Handshake: a note word is transferred on a rising clk edge where both
// note_valid and note_ready are high. note_ready is combinational,
// (state == IDLE) & en, and does not depend on note_valid. The sequencer
// holds the word stable while note_valid is high and note_ready is low.
//
// Parameters
//   DIV_W    width of the half-period field (clk cycles per tone half-period)
//   DUR_W    width of the duration field (beats)
//   GAP_CYC  silent clk cycles after every note (0 = no gap)
//   GAP_W    width of the gap counter; GAP_CYC <= 2**GAP_W
//
// Ports
//   clk               system clock, all logic on the rising edge
//   clr_n             synchronous reset, active low
//   en                run enable; low freezes state, counters and tone_out
//   beat_tick         one-cycle beat strobe from the tempo counter
//   note_valid        note word present
//   note_ready        block can accept a note (combinational)
//   note_half_period  tone half-period in clk cycles; 0 plays a rest
//   note_beats        note length in beats; 0 skips the note
//   tone_out          square-wave output (registered)
//   busy              high while a note plays or its gap runs (registered)
//   note_done         one-cycle pulse when a note finishes (registered)
//
// The FSM state is held in the enum-typed signal `state` (IDLE/PLAY/GAP) so
// that checkers can observe it directly.
// ---------------------------------------------------------------------------
module note_tone_player #(
   parameter int DIV_W   = 18,
   parameter int DUR_W   = 8,
   parameter int GAP_CYC = 1000,
   parameter int GAP_W   = 10
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic             beat_tick,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [DIV_W-1:0] note_half_period,
   input  logic [DUR_W-1:0] note_beats,
   output logic             tone_out,
   output logic             busy,
   output logic             note_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   // Gap counter preload. It counts down to 0 inclusive, so GAP_CYC-1
   // yields exactly GAP_CYC enabled cycles between note end and note_done.
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC == 0) ? '0 : GAP_W'(GAP_CYC - 1);

   state_t           state;
   logic [DIV_W-1:0] half;      // latched half-period of the current note
   logic [DIV_W-1:0] div_cnt;   // cycles left until the next tone toggle
   logic [DUR_W-1:0] beats;     // beats left in the current note
   logic [GAP_W-1:0] gap_cnt;   // cycles left in the silent gap

   logic xfer;
   logic last_beat;

   assign note_ready = (state == IDLE) && en;
   assign xfer       = note_valid && note_ready;
   // The tick that consumes the final beat ends the note.
   assign last_beat  = beat_tick && (beats == DUR_ONE);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         // Reset also abandons a note in progress, with no note_done.
         state     <= IDLE;
         half      <= '0;
         div_cnt   <= '0;
         beats     <= '0;
         gap_cnt   <= '0;
         tone_out  <= 1'b0;
         busy      <= 1'b0;
         note_done <= 1'b0;
      end else begin
         // note_done is a single-cycle pulse even while paused.
         note_done <= 1'b0;

         if (en) begin
            unique case (state)
               IDLE: begin
                  if (xfer) begin
                     if (note_beats == '0) begin
                        // Zero-length note: skip it, but report completion.
                        note_done <= 1'b1;
                     end else begin
                        half     <= note_half_period;
                        beats    <= note_beats;
                        // A rest leaves the divider parked at 0.
                        div_cnt  <= (note_half_period == '0) ? '0
                                                             : note_half_period - DIV_ONE;
                        tone_out <= 1'b0;
                        busy     <= 1'b1;
                        state    <= PLAY;
                     end
                  end
               end

               PLAY: begin
                  if (last_beat) begin
                     tone_out <= 1'b0;
                     div_cnt  <= '0;
                     beats    <= '0;
                     if (GAP_CYC != 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                     end else begin
                        busy      <= 1'b0;
                        note_done <= 1'b1;
                        state     <= IDLE;
                     end
                  end else begin
                     if (beat_tick && (beats > DUR_ONE)) begin
                        beats <= beats - DUR_ONE;
                     end
                     // Divider runs only for a pitched note; reload at 0,
                     // otherwise count down, so it never wraps.
                     if (half != '0) begin
                        if (div_cnt == '0) begin
                           div_cnt  <= half - DIV_ONE;
                           tone_out <= ~tone_out;
                        end else begin
                           div_cnt <= div_cnt - DIV_ONE;
                        end
                     end
                  end
               end

               GAP: begin
                  if (gap_cnt == '0) begin
                     busy      <= 1'b0;
                     note_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     gap_cnt <= gap_cnt - GAP_ONE;
                  end
               end

               default: begin
                  busy     <= 1'b0;
                  tone_out <= 1'b0;
                  state    <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_note_tone_player.sv
`timescale 1ns/1ps
module tb_note_tone_player;

   localparam int DIV_W = 18;
   localparam int DUR_W = 8;
   localparam int GAP   = 1000;
   localparam int GAP_W = 10;
   localparam int NVEC  = 8;

   // ---------------- clock / reset / signals ----------------
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   logic en = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance, GAP_CYC = 1000
   logic             tick, valid, ready, tone, busy, done;
   logic [DIV_W-1:0] half;
   logic [DUR_W-1:0] beats;
   // second instance, GAP_CYC = 0 (back-to-back notes)
   logic             tick0, valid0, ready0, tone0, busy0, done0;
   logic [DIV_W-1:0] half0;
   logic [DUR_W-1:0] beats0;

   note_tone_player #(.DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_CYC(GAP), .GAP_W(GAP_W)) dut (
      .clk(clk), .clr_n(clr_n), .en(en), .beat_tick(tick),
      .note_valid(valid), .note_ready(ready),
      .note_half_period(half), .note_beats(beats),
      .tone_out(tone), .busy(busy), .note_done(done)
   );

   note_tone_player #(.DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_CYC(0), .GAP_W(GAP_W)) dut0 (
      .clk(clk), .clr_n(clr_n), .en(en), .beat_tick(tick0),
      .note_valid(valid0), .note_ready(ready0),
      .note_half_period(half0), .note_beats(beats0),
      .tone_out(tone0), .busy(busy0), .note_done(done0)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];    // expected note_done cycles, main instance
   logic [31:0] exp0_q[$];   // expected note_done cycles, GAP_CYC=0 instance
   logic [31:0] exp_cyc, exp0_cyc;

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (done !== 1'b0) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: got pulse at cycle %0d want none", cyc);
         end else begin
            exp_cyc = exp_q.pop_front();
            chk("done_cycle", cyc, exp_cyc);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (done0 !== 1'b0) begin
         if (exp0_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done0_unexpected: got pulse at cycle %0d want none", cyc);
         end else begin
            exp0_cyc = exp0_q.pop_front();
            chk("done0_cycle", cyc, exp0_cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 3000 && ready !== 1'b1; i++) step();
      chk("ready_wait", ready, 1);
   endtask

   // Plays one note on the main instance. Ticks land on every edge k where
   // k % p == 0 (k counted from the transfer edge); en is low on edges in
   // [pa_s, pa_s+pa_l) and [pb_s, pb_s+pb_l). end_k/done_k/rise_k are the
   // expected note-end edge, note_done edge and first tone_out rise.
   task automatic run_note(input int h, input int b, input int p, input int xt,
                           input int pa_s, input int pa_l, input int pb_s, input int pb_l,
                           input int end_k, input int done_k, input int rise_k);
      int e, tone_err, busy_err, rdy_err, rise;
      logic exp_tone, exp_busy;
      wait_ready();
      half  = DIV_W'(h);
      beats = DUR_W'(b);
      valid = 1'b1;
      tick  = (xt != 0);          // a tick in the transfer cycle must not count
      exp_q.push_back(32'(cyc + 1 + done_k));
      step();
      valid = 1'b0;
      e = 0; tone_err = 0; busy_err = 0; rdy_err = 0; rise = -1;
      for (int k = 0; k <= done_k + 2; k++) begin
         exp_tone = (b != 0) && (h != 0) && (k < end_k) && (((e / h) % 2) == 1);
         exp_busy = (b != 0) && (k < done_k);
         if (tone !== exp_tone) tone_err++;
         if (busy !== exp_busy) busy_err++;
         if (ready !== (en && !exp_busy)) rdy_err++;
         if (rise < 0 && tone === 1'b1) rise = k;
         en   = !(((k + 1 >= pa_s) && (k + 1 < pa_s + pa_l)) ||
                  ((k + 1 >= pb_s) && (k + 1 < pb_s + pb_l)));
         tick = ((k + 1) % p) == 0;
         step();
         if (en) e++;
      end
      en   = 1'b1;
      tick = 1'b0;
      chk("tone_wave_errs", tone_err, 0);
      chk("busy_wave_errs", busy_err, 0);
      chk("ready_wave_errs", rdy_err, 0);
      chk("first_rise", rise, rise_k);
   endtask

   typedef struct {
      int h, b, p, xt, pa_s, pa_l, pb_s, pb_l, end_k, done_k, rise_k;
   } note_vec_t;

   note_vec_t vec[NVEC];

   // ---------------- test ----------------
   initial begin
      int rh, rb, rp, t_err, b_err, r_err, r4, r5, b6;
      logic exp_t, exp_b;

      //       h    b   p    xt pa_s pa_l pb_s pb_l end   done  rise
      vec[0] = '{4,   2, 100, 0,  0,   0,   0,   0,   200,  1200, 4};
      vec[1] = '{0,   3, 100, 0,  0,   0,   0,   0,   300,  1300, -1};
      vec[2] = '{7,   0, 50,  0,  0,   0,   0,   0,   0,    0,    -1};
      vec[3] = '{1,   1, 20,  1,  0,   0,   0,   0,   20,   1020, 1};
      vec[4] = '{5,   3, 37,  1,  0,   0,   0,   0,   111,  1111, 5};
      // pause 50 clk mid-PLAY with the edge-50 tick inside it, then a 20 clk
      // pause inside the gap; note ends on the ticks at 100 and 150
      vec[5] = '{4,   2, 50,  0,  30,  50,  500, 20,  150,  1170, 4};
      vec[6] = '{300, 2, 1000, 0, 0,   0,   0,   0,   2000, 3000, 300};
      rh = int'($urandom_range(12, 1));
      rb = int'($urandom_range(4, 1));
      rp = int'($urandom_range(40, 8));
      vec[7] = '{rh, rb, rp, 1, 0, 0, 0, 0, rb * rp, rb * rp + GAP, rh};

      tick = 0; valid = 0; half = '0; beats = '0;
      tick0 = 0; valid0 = 0; half0 = '0; beats0 = '0;

      // reset state
      step();
      step();
      chk("rst_tone", tone, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready_en0", ready, 0);
      en = 1'b1;
      #1;
      chk("rst_ready_en1", ready, 1);
      clr_n = 1'b1;
      step();

      // table-driven notes
      for (int i = 0; i < NVEC; i++) begin
         run_note(vec[i].h, vec[i].b, vec[i].p, vec[i].xt, vec[i].pa_s, vec[i].pa_l,
                  vec[i].pb_s, vec[i].pb_l, vec[i].end_k, vec[i].done_k, vec[i].rise_k);
      end

      // zero-beat note, then pause with note_valid held: done still clears,
      // nothing is accepted while en is low
      wait_ready();
      half = DIV_W'(7); beats = '0; valid = 1'b1;
      exp_q.push_back(32'(cyc + 1));
      step();
      chk("skip_busy", busy, 0);
      en = 1'b0;
      step();
      chk("done_clears_paused", done, 0);
      chk("ready_paused", ready, 0);
      step();
      step();
      chk("no_accept_paused", busy, 0);
      en = 1'b1; valid = 1'b0;
      step();

      // reset for one clk mid-PLAY while tone_out is high
      wait_ready();
      half = DIV_W'(4); beats = DUR_W'(2); valid = 1'b1;
      step();
      valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("pre_reset_tone", tone, 1);
      clr_n = 1'b0;
      step();
      clr_n = 1'b1;
      chk("mid_rst_tone", tone, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_ready", ready, 1);
      for (int i = 0; i < 20; i++) step();
      chk("post_rst_idle", busy, 0);
      run_note(3, 1, 25, 0, 0, 0, 0, 0, 25, 1025, 3);

      // GAP_CYC=0 instance, note_valid held across two queued notes
      half0 = DIV_W'(1); beats0 = DUR_W'(1); valid0 = 1'b1;
      exp0_q.push_back(32'(cyc + 1 + 5));
      exp0_q.push_back(32'(cyc + 1 + 14));
      step();
      half0 = DIV_W'(3); beats0 = DUR_W'(1);
      t_err = 0; b_err = 0; r_err = 0; r4 = -1; r5 = -1; b6 = -1;
      for (int k = 0; k <= 17; k++) begin
         if (k < 5)               exp_t = (k % 2) == 1;
         else if (k >= 6 && k < 14) exp_t = (((k - 6) / 3) % 2) == 1;
         else                     exp_t = 1'b0;
         exp_b = (k < 5) || (k >= 6 && k < 14);
         if (tone0 !== exp_t) t_err++;
         if (busy0 !== exp_b) b_err++;
         if (ready0 !== !exp_b) r_err++;
         if (k == 4) r4 = int'(ready0);
         if (k == 5) r5 = int'(ready0);
         if (k == 6) begin
            b6 = int'(busy0);
            valid0 = 1'b0;
         end
         tick0 = (k + 1 == 5) || (k + 1 == 14);
         step();
      end
      tick0 = 1'b0;
      chk("b2b_tone_errs", t_err, 0);
      chk("b2b_busy_errs", b_err, 0);
      chk("b2b_ready_errs", r_err, 0);
      chk("b2b_ready_before_done", r4, 0);
      chk("b2b_ready_after_done", r5, 1);
      chk("b2b_second_accepted", b6, 1);

      step();
      step();
      while (exp_q.size() > 0) begin
         exp_cyc = exp_q.pop_front();
         total++; bad++;
         $display("FAIL done_missing: got no pulse want cycle %0d", exp_cyc);
      end
      while (exp0_q.size() > 0) begin
         exp0_cyc = exp0_q.pop_front();
         total++; bad++;
         $display("FAIL done0_missing: got no pulse want cycle %0d", exp0_cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
